// File: rtl/pool_window_feeder_pkg.sv
// Shared pooling constants, state encoding and window record for the ECG max-pool front end.
// PAD_VAL doubles as the max-pool clamp floor so padded positions never win a pool.
package pool_pkg;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 6;
   localparam int POOL_W = 3;

   localparam logic signed [DATA_W-1:0] PAD_VAL = -16'sd640;

   typedef enum logic [0:0] {
      FILL   = 1'b0,
      STEADY = 1'b1
   } pool_state_e;

   typedef struct packed {
      logic signed [DATA_W-1:0] s0;
      logic signed [DATA_W-1:0] s1;
      logic signed [DATA_W-1:0] s2;
      logic                     last;
   } pool_win_t;

endpackage

// File: rtl/pool_window_feeder_if.sv
// Sample-in / window-out handshake bundle; slave is the feeder's view, master drives samples and consumes windows.
interface pool_window_feeder_if #(
   parameter int W = pool_pkg::DATA_W
);

   logic signed [W-1:0] in_data;
   logic                in_valid;
   logic                in_last;
   logic                in_ready;
   logic signed [W-1:0] win_s0;
   logic signed [W-1:0] win_s1;
   logic signed [W-1:0] win_s2;
   logic                win_valid;
   logic                win_last;
   logic                win_ready;
   logic                frame_done;

   modport slave (
      input  in_data, in_valid, in_last, win_ready,
      output in_ready, win_s0, win_s1, win_s2, win_valid, win_last, frame_done
   );

   modport master (
      output in_data, in_valid, in_last, win_ready,
      input  in_ready, win_s0, win_s1, win_s2, win_valid, win_last, frame_done
   );

endinterface

// File: rtl/pool_window_feeder_win_reg.sv
// Output window register: loads on load_i, holds contents stable until consumed via ready_i.
// Data are never cleared on drain, only the valid flag drops.
module pool_win_reg
   import pool_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      load_i,
   input  pool_win_t win_i,
   input  logic      ready_i,
   output logic      valid_o,
   output pool_win_t win_o
);

   logic      valid_q, valid_d;
   pool_win_t win_q, win_d;

   always_comb begin
      valid_d = valid_q;
      win_d   = win_q;
      if (load_i) begin
         valid_d = 1'b1;
         win_d   = win_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         win_q   <= '0;
      end else begin
         valid_q <= valid_d;
         win_q   <= win_d;
      end
   end

   assign valid_o = valid_q;
   assign win_o   = win_q;

endmodule

// File: rtl/pool_window_feeder.sv
// 3-sample window generator at STRIDE (1..3) feeding the max-pool; window valid one cycle after completing sample.
// Define POOL_FEED_PAD_EN to emit PAD_VAL-padded tail windows; otherwise partial tails are dropped.
module pool_window_feeder
   import pool_pkg::*;
#(
   parameter int STRIDE = 2
)
(
   input  logic                clk,
   input  logic                rst,
   pool_window_feeder_if.slave bus
);

   localparam logic [0:0] ST_FILL     = FILL;
   localparam logic [0:0] ST_STEADY   = STEADY;
   localparam logic [1:0] NEED_FILL   = 2'd3;
   localparam logic [1:0] NEED_STRIDE = 2'(STRIDE);

   generate
      if (STRIDE < 1 || STRIDE > 3) begin : g_bad_stride
         $error("pool_window_feeder: STRIDE must be in 1..3");
      end
   endgenerate

   logic [POOL_W-1:0][DATA_W-1:0] sh_q, sh_d;
   logic [1:0]                    need_q, need_d;
   logic [0:0]                    state_q, state_d;
   logic                          fd_q, fd_d;
   logic                          accept;
   logic                          load;
   logic                          win_vld;
   pool_win_t                     win_n;
   pool_win_t                     win_cur;

   assign bus.in_ready = ~win_vld | bus.win_ready;
   assign accept       = bus.in_valid & bus.in_ready;

   always_comb begin
      sh_d    = sh_q;
      need_d  = need_q;
      state_d = state_q;
      fd_d    = accept & bus.in_last;
      load    = 1'b0;
      win_n   = '0;
      if (accept) begin
         // With STRIDE=3 need also reloads to 3 in STEADY, so only the state tells a fresh frame apart.
         if (state_q == ST_FILL && need_q == NEED_FILL) begin
            sh_d = {bus.in_data, {DATA_W{1'b0}}, {DATA_W{1'b0}}};
         end else begin
            sh_d = {bus.in_data, sh_q[2], sh_q[1]};
         end
         need_d = need_q - 2'd1;
         if (need_q == 2'd1) begin
            load       = 1'b1;
            win_n.s0   = sh_q[1];
            win_n.s1   = sh_q[2];
            win_n.s2   = bus.in_data;
            win_n.last = bus.in_last;
            need_d     = NEED_STRIDE;
            state_d    = ST_STEADY;
         end
`ifdef POOL_FEED_PAD_EN
         else if (bus.in_last) begin
            load       = 1'b1;
            win_n.last = 1'b1;
            if (need_q == 2'd2) begin
               win_n.s0 = sh_q[2];
               win_n.s1 = bus.in_data;
               win_n.s2 = PAD_VAL;
            end else begin
               win_n.s0 = bus.in_data;
               win_n.s1 = PAD_VAL;
               win_n.s2 = PAD_VAL;
            end
         end
`endif
         if (bus.in_last) begin
            sh_d    = '0;
            need_d  = NEED_FILL;
            state_d = ST_FILL;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q    <= '0;
         need_q  <= NEED_FILL;
         state_q <= ST_FILL;
         fd_q    <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         need_q  <= need_d;
         state_q <= state_d;
         fd_q    <= fd_d;
      end
   end

   pool_win_reg u_win_reg (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .win_i   (win_n),
      .ready_i (bus.win_ready),
      .valid_o (win_vld),
      .win_o   (win_cur)
   );

   assign bus.win_s0     = win_cur.s0;
   assign bus.win_s1     = win_cur.s1;
   assign bus.win_s2     = win_cur.s2;
   assign bus.win_last   = win_cur.last;
   assign bus.win_valid  = win_vld;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Scoreboard bench: dut0 runs STRIDE=2, dut1 runs STRIDE=1; a frame-level model predicts every window.
module tb_pool_window_feeder;

   localparam logic [15:0] PADV = 16'hFD80;

   typedef struct {
      logic [15:0] s0;
      logic [15:0] s1;
      logic [15:0] s2;
      logic        last;
      int          cyc;
      bit          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0][15:0] in_data;
   logic [1:0]       in_valid, in_last, win_ready;
   logic [1:0]       in_ready, win_valid, win_last, frame_done;
   logic [1:0][15:0] ws0, ws1, ws2;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      pool_window_feeder_if u_if ();
      assign u_if.in_data   = in_data[g];
      assign u_if.in_valid  = in_valid[g];
      assign u_if.in_last   = in_last[g];
      assign u_if.win_ready = win_ready[g];
      assign in_ready[g]    = u_if.in_ready;
      assign win_valid[g]   = u_if.win_valid;
      assign win_last[g]    = u_if.win_last;
      assign frame_done[g]  = u_if.frame_done;
      assign ws0[g]         = u_if.win_s0;
      assign ws1[g]         = u_if.win_s1;
      assign ws2[g]         = u_if.win_s2;
      pool_window_feeder #(.STRIDE(g == 0 ? 2 : 1)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (u_if)
      );
   end

   int          strd [2] = '{2, 1};
   exp_t        expq [2][$];
   logic [15:0] frm  [2][$];
   bit          fd_pend [2];
   int          cyc = 0;
   bit          lat_mode = 0;
   bit          rand_rdy = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
   endtask

   // Frame-level reference: windows end at sample 3, 3+S, 3+2S...; a last sample short of that end is padded.
   task automatic model_accept(input int d, input logic [15:0] x, input bit last);
      exp_t e;
      int   n;
      int   miss;
      frm[d].push_back(x);
      n = frm[d].size();
      e.cyc = cyc + 1;
      e.lat = lat_mode;
      e.last = last;
      if (n >= 3 && ((n - 3) % strd[d]) == 0) begin
         e.s0 = frm[d][n-3];
         e.s1 = frm[d][n-2];
         e.s2 = frm[d][n-1];
         expq[d].push_back(e);
      end else if (last) begin
`ifdef POOL_FEED_PAD_EN
         miss = (n < 3) ? 3 - n : strd[d] - ((n - 3) % strd[d]);
         e.s2 = PADV;
         e.s1 = (miss == 2) ? PADV : frm[d][n-1];
         e.s0 = (miss == 2) ? frm[d][n-1] : frm[d][n-2];
         expq[d].push_back(e);
`else
         miss = 0;
`endif
      end
      if (last) frm[d].delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int d);
      in_valid[d] = 1'b0;
      in_last[d]  = 1'b0;
   endtask

   task automatic send(input int d, input logic [15:0] x, input bit last, output int waits);
      bit acc;
      acc = 0;
      waits = 0;
      in_data[d]  = x;
      in_valid[d] = 1'b1;
      in_last[d]  = last;
      while (!acc && waits <= 200) begin
         @(negedge clk);
         if (in_ready[d]) begin
            acc = 1;
            model_accept(d, x, last);
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
         if (rand_rdy) win_ready[d] = ($urandom_range(0, 3) != 0);
      end
      if (!acc) begin
         chk("accepted", d, 32'(acc), 32'd1);
         idle(d);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            fd_pend[d] = 0;
         end else begin
            if (win_valid[d] && win_ready[d]) begin
               chk("window_expected", d, 32'(expq[d].size() > 0), 32'd1);
               if (expq[d].size() > 0) begin
                  e = expq[d].pop_front();
                  chk("win_s0", d, 32'(ws0[d]), 32'(e.s0));
                  chk("win_s1", d, 32'(ws1[d]), 32'(e.s1));
                  chk("win_s2", d, 32'(ws2[d]), 32'(e.s2));
                  chk("win_last", d, 32'(win_last[d]), 32'(e.last));
                  if (e.lat) chk("latency_cycle", d, 32'(cyc), 32'(e.cyc));
               end
            end
            if (fd_pend[d] || frame_done[d]) chk("frame_done", d, 32'(frame_done[d]), 32'(fd_pend[d]));
            fd_pend[d] = in_valid[d] && in_ready[d] && in_last[d];
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      in_data   = '0;
      in_last   = '0;
      win_ready = '1;
      in_valid  = '1;
      rst       = 1'b1;
      tick(3);
      for (int d = 0; d < 2; d++) begin
         chk("rst_win_valid", d, 32'(win_valid[d]), 32'd0);
         chk("rst_win_s0", d, 32'(ws0[d]), 32'd0);
         chk("rst_win_s1", d, 32'(ws1[d]), 32'd0);
         chk("rst_win_s2", d, 32'(ws2[d]), 32'd0);
         chk("rst_win_last", d, 32'(win_last[d]), 32'd0);
         chk("rst_frame_done", d, 32'(frame_done[d]), 32'd0);
      end
      in_valid = '0;
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("post_rst_in_ready", d, 32'(in_ready[d]), 32'd1);
      tick(1);

      // Basic STRIDE=2 frame
      lat_mode = 1;
      send(0, 16'd64, 0, w);
      send(0, 16'd128, 0, w);
      send(0, 16'd192, 0, w);
      send(0, 16'd256, 0, w);
      send(0, 16'd320, 1, w);
      idle(0);
      tick(3);

      // Backpressure hold
      lat_mode = 0;
      win_ready[0] = 1'b0;
      send(0, 16'd64, 0, w);
      send(0, 16'd128, 0, w);
      send(0, 16'd192, 0, w);
      idle(0);
      for (int i = 0; i < 10 && !win_valid[0]; i++) @(negedge clk);
      chk("bp_window_up", 0, 32'(win_valid[0]), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 0, 32'(in_ready[0]), 32'd0);
         chk("bp_valid_hold", 0, 32'(win_valid[0]), 32'd1);
         chk("bp_s0_hold", 0, 32'(ws0[0]), 32'd64);
         chk("bp_s1_hold", 0, 32'(ws1[0]), 32'd128);
         chk("bp_s2_hold", 0, 32'(ws2[0]), 32'd192);
      end
      @(posedge clk);
      #1;
      win_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", 0, 32'(in_ready[0]), 32'd1);
      @(negedge clk);
      chk("bp_drained", 0, 32'(win_valid[0]), 32'd0);
      tick(1);
      lat_mode = 1;
      send(0, 16'd256, 0, w);
      send(0, 16'd320, 1, w);
      idle(0);
      tick(3);

      // Partial tail and single-sample frame
      send(0, 16'd64, 0, w);
      send(0, 16'd128, 0, w);
      send(0, 16'd192, 0, w);
      send(0, 16'd256, 1, w);
      idle(0);
      tick(3);
      send(0, 16'd64, 1, w);
      send(0, 16'd10, 0, w);
      send(0, 16'd20, 0, w);
      send(0, 16'd30, 0, w);
      send(0, 16'd40, 1, w);
      idle(0);
      tick(3);

      // STRIDE=1 back-to-back, then reset mid-stream
      for (int i = 0; i < 10; i++) begin
         send(1, 16'(100 + i * 7), i == 9, w);
         chk("s1_no_bubble", 1, 32'(w), 32'd0);
      end
      idle(1);
      tick(3);
      for (int i = 0; i < 5; i++) send(1, 16'(500 + i), 0, w);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid_drop", 1, 32'(win_valid[1]), 32'd0);
      chk("mid_rst_frame_done", 1, 32'(frame_done[1]), 32'd0);
      idle(1);
      for (int d = 0; d < 2; d++) begin
         expq[d].delete();
         frm[d].delete();
      end
      tick(1);
      rst = 1'b0;
      tick(1);
      send(1, 16'd1, 0, w);
      send(1, 16'd2, 0, w);
      send(1, 16'd3, 0, w);
      idle(1);
      tick(3);

      // Randomized traffic with random backpressure
      lat_mode = 0;
      rand_rdy = 1;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 5) == 0) begin
               idle(d);
               tick(1);
            end
            send(d, 16'($urandom), $urandom_range(0, 7) == 0, w);
         end
         idle(d);
      end
      rand_rdy = 0;
      win_ready = '1;
      tick(10);
      for (int d = 0; d < 2; d++) chk("scoreboard_drained", d, 32'(expq[d].size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pool_window_feeder.md
# pool_window_feeder

Streaming window generator that sits directly upstream of the 3-input max-pool unit in the ECG inference datapath. It accepts one Q9.6 conv/activation sample per cycle over a valid/ready handshake, keeps the last three samples, and presents registered 3-sample windows (S0, S1, S2) at a configurable stride. It also marks frame boundaries and pads partial tail windows with the pooling floor value.

## Interface
- DATA_W, 16, sample width (signed Q9.6: 1 sign, 9 integer, 6 fractional bits)
- STRIDE, 2, samples between successive windows; legal range 1..3; any other value is an elaboration error
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- in_data  in  DATA_W  signed input sample
- in_valid  in  1  in_data valid
- in_last  in  1  qualifies the final sample of a frame
- in_ready  out  1  sample accepted when in_valid & in_ready
- win_s0 / win_s1 / win_s2  out  DATA_W each  window, oldest (s0) to newest (s2)
- win_valid  out  1  window valid
- win_last  out  1  window is the last window of the frame
- win_ready  in  1  window consumed when win_valid & win_ready
- frame_done  out  1  one-cycle pulse in the cycle after an in_last sample is accepted

## Operation
- Storage: 3-entry shift register sh[0..2], a need counter (2 bits), state FILL/STEADY, and an output window register.
- in_ready = ~win_valid | win_ready (combinational). This gives one sample per cycle with no bubble.
- Accepting a sample:
  - shifts the register: {sh1, sh2, in_data};
  - decrements need.
- When need reaches 0:
  - the shifted window loads into the output register and win_valid is set;
  - need reloads to STRIDE;
  - state goes to STEADY.
- FILL: need starts at 3, so the first window is emitted after 3 samples.
- in_last on an accepted sample that completes a window: that window has win_last=1; the block returns to FILL with need=3 and sh cleared.
- in_last on an accepted sample that does not complete a window: handled per Configuration. Either way the block returns to FILL with need=3.
- A window drains when win_valid & win_ready. If a new window is produced in the same cycle, the output register reloads and win_valid stays 1.
- No arithmetic on data; samples pass bit-exact.
- PAD_VAL = -640 (-10.0 in Q9.6). This equals the max-pool clamp floor, so padding never raises a pooled result above the floor.

## Timing
- Latency: the window is valid on the cycle after the completing sample is accepted.
- Throughput: 1 sample/cycle sustained.
- Window rate: 1 window per STRIDE samples; with STRIDE=1, one window per cycle after fill.
- Backpressure: while win_valid & ~win_ready, in_ready=0 and all win_* outputs hold stable.
- frame_done asserts one cycle after the in_last acceptance, coincident with win_valid of any last window.
- Reset values (asynchronous, immediate):
  - win_s0/s1/s2 = 0, win_valid = 0, win_last = 0, frame_done = 0;
  - sh = 0, need = 3, state = FILL;
  - in_ready = 1 once win_valid is 0.
- Reset mid-frame discards pending windows and partial samples; the next accepted sample starts a new frame.
- in_last on the very first sample of a frame is legal (see Configuration).

## Configuration
- POOL_FEED_PAD_EN defined: an in_last that leaves need>0 emits one padded window with win_last=1. Missing newer positions are filled with PAD_VAL:
  - need=1 gives {sh2_old, in_data, PAD};
  - need=2 gives {in_data, PAD, PAD};
  - the same rule applies in FILL, so a 1-sample frame gives {x, PAD, PAD}.
- Undefined: the partial tail is dropped. No window and no win_last are produced for it; frame_done still pulses.

## Structure
- Shared package pool_pkg holds:
  - DATA_W = 16 and FRAC_W = 6;
  - POOL_W = 3;
  - PAD_VAL = -640 (same constant as the pooling clamp floor);
  - the FILL/STEADY state enum;
  - the window struct {s0, s1, s2, last}.
- One sub-module, pool_win_reg: the output window register with valid/ready hold logic. Shift register, counter and FSM stay in the top module.

## Test plan
- Reset: hold RST with in_valid=1 → win_valid=0, win_s*=0, frame_done=0; after release in_ready=1 and the first window needs 3 samples.
- STRIDE=2, win_ready=1, stream 64,128,192,256,320 (last on 320) → window (64,128,192) one cycle after 192; then (192,256,320) with win_last=1; frame_done pulses with it.
- Backpressure: hold win_ready=0 while (64,128,192) is pending → in_ready=0, outputs stable for 5 cycles; raise win_ready → window drains that cycle and in_ready=1.
- Tail with PAD_EN, STRIDE=2: 64,128,192,256(last) → (64,128,192), then (192,256,-640) with win_last=1. Without PAD_EN: only the first window is produced, and frame_done pulses.
- Short frame with PAD_EN: single sample 64 with in_last → (64,-640,-640) with win_last=1; the next frame restarts in FILL.
- STRIDE=1 back-to-back: 10 consecutive samples, win_ready=1 → 8 windows on consecutive cycles with no in_ready drop; pulse RST mid-stream → win_valid drops immediately and the next frame needs 3 fresh samples.
